// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU transmit path.
//   - state_t     : one-hot scheduler state encoding (8 bits)
//   - crc_phase_t : which byte class the scheduler is currently sending
//   - CRC_POLY / CRC_INIT : Modbus CRC-16 constants (reflected 0xA001, init 0xFFFF)
//   - gap_cycles() : inter-frame silence length in clock cycles
package modbus_pkg;

  typedef enum logic [7:0] {
    S_IDLE   = 8'b0000_0001,
    S_FETCH  = 8'b0000_0010,
    S_LOAD   = 8'b0000_0100,
    S_START  = 8'b0000_1000,
    S_WAIT   = 8'b0001_0000,
    S_CRC_LO = 8'b0010_0000,
    S_CRC_HI = 8'b0100_0000,
    S_GAP    = 8'b1000_0000
  } state_t;

  typedef enum logic [1:0] {
    PH_DATA   = 2'd0,
    PH_CRC_LO = 2'd1,
    PH_CRC_HI = 2'd2
  } crc_phase_t;

  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // 3.5 character times at low baud rates, fixed 1.75 ms above 19200 baud.
  // 64-bit intermediates: CLK_FREQ*1750 overflows 32 bits at 50 MHz.
  function automatic int gap_cycles(input longint clk_freq, input longint baud_rate);
    longint g;
    if (baud_rate <= 64'd19200) g = (clk_freq * 64'd385) / (baud_rate * 64'd10);
    else                        g = (clk_freq * 64'd1750) / 64'd1000000;
    return int'(g);
  endfunction

endpackage

// File: rtl/modbus_tx_sched_crc16.sv
// Modbus CRC-16 single-byte update, purely combinational.
//   crc_in  : running CRC before this byte
//   data    : byte being added
//   crc_out : running CRC after this byte
// Only instantiated by modbus_tx_sched when MODBUS_TX_CRC_EN is defined.
module modbus_crc16
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // Reflected (LSB-first) shift, one iteration per data bit.
  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/modbus_tx_sched.sv
// Modbus RTU slave frame transmit scheduler.
// Reads frame_len bytes from a 1-cycle-latency frame buffer, hands each to
// uart_byte_tx via tx_start/tx_data/tx_done, optionally appends the CRC-16
// (low byte first), then holds frame_busy for the RTU inter-frame silence.
//
// Optional feature macro: MODBUS_TX_CRC_EN (append CRC-16 when defined).
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   frame_req, frame_len  : one-cycle request and payload length (1..2^(LEN_W-1))
//   frame_busy            : request accepted until silence gap has elapsed
//   frame_done, frame_err : completion pulse / rejected-request pulse
//   buf_rd_addr/data      : frame buffer read port
//   tx_start, tx_data     : byte start strobe and byte to the UART
//   tx_done, tx_state     : UART end-of-byte pulse and UART busy level
module modbus_tx_sched
  import modbus_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int LEN_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_req,
  input  logic [LEN_W-1:0] frame_len,
  output logic             frame_busy,
  output logic             frame_done,
  output logic             frame_err,
  output logic [LEN_W-2:0] buf_rd_addr,
  input  logic [7:0]       buf_rd_data,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  input  logic             tx_state
);

  localparam int AW         = LEN_W - 1;
  localparam int GAP_CYCLES = gap_cycles(CLK_FREQ, BAUD_RATE);
  localparam int GAP_W      = ($clog2(GAP_CYCLES) > 0) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           state, state_next;
  logic [LEN_W-1:0] len_q;
  logic [AW-1:0]    idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             len_ok, last_byte, gap_end;
  logic             accept, reject, advance, finish;

  // Legal lengths are 1 .. 2^(LEN_W-1): nonzero, and either top bit clear or
  // exactly the power of two.
  assign len_ok    = (frame_len != '0) &&
                     (!frame_len[LEN_W-1] || (frame_len[LEN_W-2:0] == '0));
  assign last_byte = ({1'b0, idx} == (len_q - LEN_W'(1)));
  assign gap_end   = (gap_cnt == GAP_LAST);
  assign buf_rd_addr = idx;

`ifdef MODBUS_TX_CRC_EN
  crc_phase_t  phase;
  logic [15:0] crc, crc_next;

  modbus_crc16 u_crc (
    .crc_in  (crc),
    .data    (buf_rd_data),
    .crc_out (crc_next)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_req) begin
          // tx_state guards against a byte still draining from before a reset.
          if (len_ok && !tx_state) begin
            accept     = 1'b1;
            state_next = S_FETCH;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        if (tx_done) begin
`ifdef MODBUS_TX_CRC_EN
          case (phase)
            PH_CRC_LO: state_next = S_CRC_HI;
            PH_CRC_HI: begin
              finish     = 1'b1;
              state_next = S_GAP;
            end
            default: begin
              if (last_byte) begin
                state_next = S_CRC_LO;
              end else begin
                advance    = 1'b1;
                state_next = S_FETCH;
              end
            end
          endcase
`else
          if (last_byte) begin
            finish     = 1'b1;
            state_next = S_GAP;
          end else begin
            advance    = 1'b1;
            state_next = S_FETCH;
          end
`endif
        end
      end
`ifdef MODBUS_TX_CRC_EN
      S_CRC_LO, S_CRC_HI: state_next = S_START;
`endif
      S_GAP:   if (gap_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      idx        <= '0;
      len_q      <= '0;
      gap_cnt    <= '0;
    end else begin
      frame_busy <= (state_next != S_IDLE);
      frame_done <= finish;
      frame_err  <= reject;
      tx_start   <= (state_next == S_START);
      // Counter is zero on GAP entry, so IDLE follows exactly GAP_CYCLES
      // edges after the edge that raised frame_done.
      gap_cnt    <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (accept) begin
        len_q <= frame_len;
        idx   <= '0;
      end else if (advance) begin
        idx <= idx + AW'(1);
      end
      if (state == S_LOAD) tx_data <= buf_rd_data;
`ifdef MODBUS_TX_CRC_EN
      else if (state == S_CRC_LO) tx_data <= crc[7:0];
      else if (state == S_CRC_HI) tx_data <= crc[15:8];
`endif
    end
  end

`ifdef MODBUS_TX_CRC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      crc   <= CRC_INIT;
      phase <= PH_DATA;
    end else begin
      if (accept) begin
        crc   <= CRC_INIT;
        phase <= PH_DATA;
      end else begin
        if (state == S_LOAD) crc <= crc_next;
        if (state == S_CRC_LO)      phase <= PH_CRC_LO;
        else if (state == S_CRC_HI) phase <= PH_CRC_HI;
      end
    end
  end
`endif

endmodule

// File: tb/tb_modbus_tx_sched.sv
// Testbench for modbus_tx_sched (works with or without MODBUS_TX_CRC_EN).
// Clock 100 kHz nominal, 115200 baud -> 1.75 ms silence = 175 cycles.
// A behavioural UART (fixed byte time) and a synchronous RAM model surround
// the DUT; expected line bytes are queued when a frame is requested and
// popped as tx_start strobes appear.
module tb_modbus_tx_sched;

  localparam int LEN_W    = 9;
  localparam int GAP      = 175;
  localparam int UART_CYC = 20;
  localparam logic [7:0] FRAME_A [6] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
  localparam logic [7:0] FRAME_B [4] = '{8'hC2, 8'hB3, 8'hA4, 8'h95};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             frame_req = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             frame_busy, frame_done, frame_err;
  logic [LEN_W-2:0] buf_rd_addr;
  logic [7:0]       buf_rd_data;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_done, tx_state;

  logic       m_done = 1'b0, m_busy = 1'b0, inj_done = 1'b0, m_abort = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] mem [256];
  logic [7:0] sb [$];

  int   checks = 0, errors = 0;
  int   cyc = 0, starts = 0, dones = 0, pay_left = 0;
  int   d3_c = 0, done_c = 0, mdone_c = 0;
  logic pend3 = 1'b0, pend_gap = 1'b0, prev_start = 1'b0, prev_busy = 1'b0;

  assign tx_done  = m_done | inj_done;
  assign tx_state = m_busy;

  modbus_tx_sched #(
    .CLK_FREQ  (100000),
    .BAUD_RATE (115200),
    .LEN_W     (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_req   (frame_req),
    .frame_len   (frame_len),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .tx_state    (tx_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) buf_rd_data <= mem[buf_rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC over mem[0..len-1].
  function automatic logic [15:0] ref_crc(input int len);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ mem[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    end
    return c;
  endfunction

  task automatic push_payload(input int len);
    for (int i = 0; i < len; i++) sb.push_back(mem[i]);
  endtask

  task automatic push_crc(input int len);
`ifdef MODBUS_TX_CRC_EN
    logic [15:0] c;
    c = ref_crc(len);
    sb.push_back(c[7:0]);
    sb.push_back(c[15:8]);
`else
    if (len < 0) sb.delete();
`endif
  endtask

  task automatic request(input int len);
    frame_len = LEN_W'(len);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic expect_first_start(input string tag);
    int k = 0;
    while (!tx_start && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, k, 2);
  endtask

  task automatic wait_frame_done(input string tag);
    int k = 0;
    while (!frame_done && k < 10000) begin
      @(negedge clk);
      k++;
    end
    check(tag, (k < 10000), 1);
  endtask

  task automatic wait_busy_low(input string tag);
    int k = 0;
    while (frame_busy && k < 10000) begin
      @(negedge clk);
      k++;
    end
    check(tag, (k < 10000), 1);
  endtask

  // UART model and scoreboard monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (m_busy) begin
      if (m_cnt == 1) begin
        m_done  = 1'b1;
        m_busy  = 1'b0;
        mdone_c = cyc;
        if (!m_abort) check("tx_data_hold", tx_data, m_byte);
        m_abort = 1'b0;
        if (frame_busy && pay_left > 0) begin
          pend3 = 1'b1;
          d3_c  = cyc;
        end
      end
      m_cnt--;
    end
    if (tx_start) begin
      starts++;
      check("tx_start_width", prev_start, 0);
      check("uart_overlap", m_busy, 0);
      check("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) check("line_byte", tx_data, sb.pop_front());
      if (pend3) begin
        check("start_after_done", cyc - d3_c, 3);
        pend3 = 1'b0;
      end
      if (pay_left > 0) pay_left--;
      m_busy = 1'b1;
      m_cnt  = UART_CYC;
      m_byte = tx_data;
    end
    prev_start = tx_start;
    if (frame_done) begin
      dones++;
      check("done_on_last", cyc - mdone_c, 1);
      check("done_sb_empty", sb.size(), 0);
      pend_gap = 1'b1;
      done_c   = cyc;
    end
    if (pend_gap && prev_busy && !frame_busy) begin
      check("gap_len", cyc - done_c, GAP);
      pend_gap = 1'b0;
    end
    prev_busy = frame_busy;
  end

  initial begin
    int d0, s0, k;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", frame_busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_err, 0);
    check("rst_start", tx_start, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_addr", buf_rd_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Frame A: Modbus read-holding-register request, known CRC 84 0A
    for (int i = 0; i < 6; i++) mem[i] = FRAME_A[i];
    push_payload(6);
`ifdef MODBUS_TX_CRC_EN
    sb.push_back(8'h84);
    sb.push_back(8'h0A);
`endif
    pay_left = 6;
    d0 = dones;
    request(6);
    check("accept_a", frame_busy, 1);
    expect_first_start("first_start_a");
    repeat (5) @(negedge clk);
    request(6);
    check("req_in_wait_err", frame_err, 0);
    check("req_in_wait_busy", frame_busy, 1);
    wait_frame_done("done_a");
    repeat (10) @(negedge clk);
    request(6);
    check("req_in_gap_err", frame_err, 0);
    wait_busy_low("busy_low_a");
    check("done_count_a", dones - d0, 1);
    check("sb_empty_a", sb.size(), 0);

    // Frame B: requested one cycle after busy falls
    for (int i = 0; i < 4; i++) mem[i] = FRAME_B[i];
    push_payload(4);
    push_crc(4);
    pay_left = 4;
    d0 = dones;
    @(negedge clk);
    request(4);
    check("accept_b", frame_busy, 1);
    expect_first_start("first_start_b");
    wait_frame_done("done_b");
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (3) @(negedge clk);
    check("gap_done_busy", frame_busy, 1);
    check("gap_done_start", tx_start, 0);
    wait_busy_low("busy_low_b");
    check("done_count_b", dones - d0, 1);
    check("sb_empty_b", sb.size(), 0);

    // Stray tx_done while idle
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_done_busy", frame_busy, 0);
    check("idle_done_start", tx_start, 0);
    check("idle_done_fd", frame_done, 0);
    check("idle_done_err", frame_err, 0);

    // Illegal lengths
    request(0);
    check("len0_err", frame_err, 1);
    check("len0_busy", frame_busy, 0);
    @(negedge clk);
    check("len0_err_pulse", frame_err, 0);
    repeat (5) @(negedge clk);
    check("len0_busy_late", frame_busy, 0);
    request(257);
    check("len257_err", frame_err, 1);
    check("len257_busy", frame_busy, 0);
    @(negedge clk);
    check("len257_err_pulse", frame_err, 0);
    repeat (5) @(negedge clk);
    check("len257_busy_late", frame_busy, 0);

    // Reset in the middle of frame C
    for (int i = 0; i < 5; i++) mem[i] = 8'($urandom);
    push_payload(5);
    push_crc(5);
    pay_left = 5;
    s0 = starts;
    request(5);
    k = 0;
    while (starts < s0 + 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("second_start_c", (k < 500), 1);
    rst     = 1'b1;
    m_abort = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", frame_busy, 0);
    check("mid_rst_done", frame_done, 0);
    check("mid_rst_err", frame_err, 0);
    check("mid_rst_start", tx_start, 0);
    check("mid_rst_data", tx_data, 8'h00);
    check("mid_rst_addr", buf_rd_addr, 0);
    rst = 1'b0;
    sb.delete();
    pay_left = 0;
    pend3    = 1'b0;
    @(negedge clk);
    request(5);
    check("busy_uart_err", frame_err, 1);
    check("busy_uart_busy", frame_busy, 0);
    k = 0;
    while (tx_state && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("uart_drain", (k < 100), 1);
    @(negedge clk);

    // Frame D: maximum length 256 after the drained byte
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    push_payload(256);
    push_crc(256);
    pay_left = 256;
    d0 = dones;
    request(256);
    check("accept_d", frame_busy, 1);
    check("accept_d_err", frame_err, 0);
    expect_first_start("first_start_d");
    wait_busy_low("busy_low_d");
    check("done_count_d", dones - d0, 1);
    check("sb_empty_d", sb.size(), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
